// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: VIC/CPU/DMA request ports plus the memCtrl strobe/status bus
interface mem_arbiter_if;
  logic i_vic_req;
  logic [23:0] i_vic_addr;
  logic o_vic_ack;
  logic [7:0] o_vic_data;
  logic i_cpu_req;
  logic i_cpu_write;
  logic [23:0] i_cpu_addr;
  logic [7:0] i_cpu_wdata;
  logic o_cpu_ack;
  logic [7:0] o_cpu_data;
  logic i_dma_req;
  logic i_dma_write;
  logic [23:0] i_dma_addr;
  logic [7:0] i_dma_wdata;
  logic o_dma_ack;
  logic [7:0] o_dma_data;
  logic o_mem_cs;
  logic o_mem_write;
  logic [23:0] o_mem_address;
  logic [7:0] o_mem_dataToWrite;
  logic i_mem_busy;
  logic i_mem_dataReady;
  logic [7:0] i_mem_dataRead;
  logic [1:0] o_grant;
  logic o_timeout;
  modport master (
    output i_vic_req, i_vic_addr, i_cpu_req, i_cpu_write, i_cpu_addr, i_cpu_wdata,
           i_dma_req, i_dma_write, i_dma_addr, i_dma_wdata, i_mem_busy, i_mem_dataReady, i_mem_dataRead,
    input o_vic_ack, o_vic_data, o_cpu_ack, o_cpu_data, o_dma_ack, o_dma_data,
          o_mem_cs, o_mem_write, o_mem_address, o_mem_dataToWrite, o_grant, o_timeout
  );
  modport slave (
    input i_vic_req, i_vic_addr, i_cpu_req, i_cpu_write, i_cpu_addr, i_cpu_wdata,
          i_dma_req, i_dma_write, i_dma_addr, i_dma_wdata, i_mem_busy, i_mem_dataReady, i_mem_dataRead,
    output o_vic_ack, o_vic_data, o_cpu_ack, o_cpu_data, o_dma_ack, o_dma_data,
           o_mem_cs, o_mem_write, o_mem_address, o_mem_dataToWrite, o_grant, o_timeout
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: VIC > CPU > DMA arbiter in front of memCtrl; MEM_ARB_STARVE_GUARD_EN adds DMA starvation promotion
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
`ifdef MEM_ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 8
`endif
) (
  input logic i_clkRAM,
  input logic reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, ACK} state_t;
  state_t state, state_nx;
  logic [1:0] win;
  logic [15:0] timer;
  logic [7:0] cap_val;
  logic waiting, done, tmo, cap, grant_now, promote;
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve;
  assign promote = bus.i_dma_req && starve >= 4'(STARVE_LIMIT);
`else
  assign promote = 1'b0;
`endif
  assign win = bus.i_mem_busy ? 2'd0 : promote ? 2'd3 : bus.i_vic_req ? 2'd1 :
               bus.i_cpu_req ? 2'd2 : bus.i_dma_req ? 2'd3 : 2'd0;
  assign grant_now = state == IDLE && win != 2'd0;
  assign waiting = state == WAIT_START || state == WAIT_DONE;
  // memCtrl may finish a read before busy is ever seen high
  assign done = (state == WAIT_START && bus.i_mem_dataReady) ||
                (state == WAIT_DONE && (bus.o_mem_write ? !bus.i_mem_busy : bus.i_mem_dataReady));
  assign tmo = waiting && !done && timer == 16'(TIMEOUT_CYCLES - 1);
  assign cap = (done || tmo) && !bus.o_mem_write;
  assign cap_val = tmo ? 8'h00 : bus.i_mem_dataRead;
  assign bus.o_vic_ack = state == ACK && bus.o_grant == 2'd1;
  assign bus.o_cpu_ack = state == ACK && bus.o_grant == 2'd2;
  assign bus.o_dma_ack = state == ACK && bus.o_grant == 2'd3;
  always_ff @(posedge i_clkRAM) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = grant_now ? ISSUE : IDLE;
      ISSUE: state_nx = WAIT_START;
      WAIT_START: state_nx = done || tmo ? ACK : bus.i_mem_busy ? WAIT_DONE : WAIT_START;
      WAIT_DONE: state_nx = done || tmo ? ACK : WAIT_DONE;
      ACK: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clkRAM) begin
    if (reset) begin
      bus.o_mem_cs <= 1'b1;
      bus.o_mem_write <= 1'b0;
      bus.o_mem_address <= 24'h0;
      bus.o_mem_dataToWrite <= 8'h00;
      bus.o_vic_data <= 8'h00;
      bus.o_cpu_data <= 8'h00;
      bus.o_dma_data <= 8'h00;
      bus.o_grant <= 2'd0;
      bus.o_timeout <= 1'b0;
      timer <= 16'd0;
    end else begin
      bus.o_mem_cs <= !grant_now;
      if (grant_now) begin
        bus.o_grant <= win;
        bus.o_mem_address <= win == 2'd1 ? bus.i_vic_addr : win == 2'd2 ? bus.i_cpu_addr : bus.i_dma_addr;
        bus.o_mem_write <= win == 2'd2 ? bus.i_cpu_write : win == 2'd3 ? bus.i_dma_write : 1'b0;
        bus.o_mem_dataToWrite <= win == 2'd2 ? bus.i_cpu_wdata : win == 2'd3 ? bus.i_dma_wdata : 8'h00;
      end
      if (state == ACK) bus.o_grant <= 2'd0;
      timer <= state == ISSUE ? 16'd0 : waiting ? timer + 16'd1 : timer;
      if (tmo) bus.o_timeout <= 1'b1;
      if (cap && bus.o_grant == 2'd1) bus.o_vic_data <= cap_val;
      if (cap && bus.o_grant == 2'd2) bus.o_cpu_data <= cap_val;
      if (cap && bus.o_grant == 2'd3) bus.o_dma_data <= cap_val;
    end
  end
`ifdef MEM_ARB_STARVE_GUARD_EN
  always_ff @(posedge i_clkRAM) begin
    if (reset) starve <= 4'd0;
    else if (grant_now && win == 2'd3) starve <= 4'd0;
    else if (grant_now && bus.i_dma_req && starve != 4'hF) starve <= starve + 4'd1;
  end
`endif
endmodule
